alu_result_uart_tx: RTL and testbench

Serial result reporter for the FPGA ALU demo. It captures one 32-bit ALU result plus its NZC flags through a valid/ready handshake. It then transmits the pair as a 14-character ASCII line over an 8N1 UART TX pin. It is the outbound counterpart to the switch/button operand entry path: operands go in by hand and results go out to a host terminal.

---
 rtl/alu_result_uart_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_result_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx
// Captures one 32-bit ALU result plus NZC flags over a valid/ready handshake
// and reports it on a UART TX pin as the 14-character ASCII line
// "HHHHHHHH NZC\r\n" (uppercase hex, '-' for a clear flag).
// Framing is 8N1 by default. Defining UART_EVEN_PARITY_EN adds an even-parity
// bit after data bit 7, which makes each frame 11 bits long.
// All outputs are registered. tx goes low for the first start bit in the cycle
// after capture, and frames follow each other with no idle gap.

module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [2:0]  nzc,
  output logic        tx,
  output logic        done
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_CHAR = 4'd13;

`ifdef UART_EVEN_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  // Converts one nibble to its uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Returns the character at position idx of the report line.
  function automatic logic [7:0] line_char(input logic [31:0] r,
                                           input logic [2:0]  f,
                                           input logic [3:0]  idx);
    logic [7:0] c;
    c = 8'h0A;
    case (idx)
      4'd0:    c = hex_ascii(r[31:28]);
      4'd1:    c = hex_ascii(r[27:24]);
      4'd2:    c = hex_ascii(r[23:20]);
      4'd3:    c = hex_ascii(r[19:16]);
      4'd4:    c = hex_ascii(r[15:12]);
      4'd5:    c = hex_ascii(r[11:8]);
      4'd6:    c = hex_ascii(r[7:4]);
      4'd7:    c = hex_ascii(r[3:0]);
      4'd8:    c = 8'h20;
      4'd9:    c = f[2] ? 8'h4E : 8'h2D;
      4'd10:   c = f[1] ? 8'h5A : 8'h2D;
      4'd11:   c = f[0] ? 8'h43 : 8'h2D;
      4'd12:   c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  // Control state (reset)
  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q,  baud_d;
  logic [2:0]       bit_q,   bit_d;
  logic [3:0]       char_q,  char_d;
  logic             tx_q,    tx_d;
  logic             ready_q, ready_d;
  logic             done_q,  done_d;

  // Datapath state (no reset)
  logic [31:0]      res_q,   res_d;
  logic [2:0]       flags_q, flags_d;
  logic [7:0]       shreg_q, shreg_d;
`ifdef UART_EVEN_PARITY_EN
  logic             par_q,   par_d;
`endif

  logic             bit_end;
  logic [7:0]       load_byte;

  assign bit_end = (baud_q == BAUD_LAST);

  // At capture time the first character is built from the input ports because
  // the latch is still being written. After that, only latched data is used.
  assign load_byte = (state_q == IDLE) ? line_char(result, nzc, 4'd0)
                                       : line_char(res_q, flags_q, char_q + 4'd1);

  // Next-state logic and the next value of every registered output
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    res_d   = res_q;
    flags_d = flags_q;
    shreg_d = shreg_q;
`ifdef UART_EVEN_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (in_valid && ready_q) begin
          res_d   = result;
          flags_d = nzc;
          char_d  = 4'd0;
          baud_d  = '0;
          shreg_d = load_byte;
`ifdef UART_EVEN_PARITY_EN
          par_d   = ^load_byte;
`endif
          tx_d    = 1'b0;
          ready_d = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_EVEN_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end

`ifdef UART_EVEN_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          if (char_q == LAST_CHAR) begin
            state_d = IDLE;
            char_d  = 4'd0;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            char_d  = char_q + 4'd1;
            shreg_d = load_byte;
`ifdef UART_EVEN_PARITY_EN
            par_d   = ^load_byte;
`endif
            tx_d    = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control and output registers; reset wins over a simultaneous capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      char_q  <= 4'd0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Latched result and character shift register; always reloaded at capture
  always_ff @(posedge clk) begin
    res_q   <= res_d;
    flags_q <= flags_d;
    shreg_q <= shreg_d;
`ifdef UART_EVEN_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx       = tx_q;
  assign in_ready = ready_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Testbench for alu_result_uart_tx at CLKS_PER_BIT=4.
// Decodes the serial line at mid-bit and checks the characters against
// hand-written ASCII lines, the framing, the handshake, the done timing,
// and behaviour on reset and on ignored captures.

module tb_alu_result_uart_tx;

  localparam int CPB = 4;
`ifdef UART_EVEN_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int CHAR_CYC = FRAME * CPB;
  localparam int LINE_CYC = 14 * CHAR_CYC;

  // Expected lines, byte 0 in the most-significant position
  localparam logic [111:0] L_1E     = 112'h3030_3030_3030_3145_202D_2D2D_0D0A; // "0000001E ---"
  localparam logic [111:0] L_FFFD   = 112'h4646_4646_4646_4644_204E_2D2D_0D0A; // "FFFFFFFD N--"
  localparam logic [111:0] L_89AB   = 112'h3839_4142_4344_4546_202D_2D43_0D0A; // "89ABCDEF --C"
  localparam logic [111:0] L_C0FFEE = 112'h3030_4330_4646_4545_204E_5A43_0D0A; // "00C0FFEE NZC"
  localparam logic [111:0] L_0A     = 112'h3030_3030_3030_3041_202D_5A2D_0D0A; // "0000000A -Z-"

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] result = 32'h0;
  logic [2:0]  nzc = 3'b000;
  logic        tx;
  logic        in_ready;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .nzc      (nzc),
    .tx       (tx),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one capture; returns 1 time unit after the capture edge
  task automatic capture(input logic [31:0] r, input logic [2:0] f);
    result   = r;
    nzc      = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Decodes a full line starting in the first start-bit cycle and returns in
  // the cycle where done should be high. With inject set, a second capture
  // attempt is presented in the middle of the line.
  task automatic check_line(input string name, input logic [111:0] exp, input bit inject);
    logic [FRAME-1:0] fr;
    int rdy_bad;
    int done_bad;
    rdy_bad  = 0;
    done_bad = 0;
    fr       = '0;
    chk($sformatf("%s start latency", name), 32'(tx), 32'(1'b0));
    for (int t = 0; t < LINE_CYC; t++) begin
      if (in_ready !== 1'b0) rdy_bad++;
      if (done !== 1'b0) done_bad++;
      if (inject && t == 5 * CHAR_CYC) begin
        result   = 32'h12345678;
        nzc      = 3'b111;
        in_valid = 1'b1;
      end
      if (inject && t == 5 * CHAR_CYC + 3) in_valid = 1'b0;
      if (t % CPB == CPB / 2) fr[(t / CPB) % FRAME] = tx;
      if (t % CHAR_CYC == CHAR_CYC - 1) begin
        int c;
        logic [7:0] eb;
        c  = t / CHAR_CYC;
        eb = exp[111 - 8 * c -: 8];
        chk($sformatf("%s char%0d", name, c), 32'(fr[8:1]), 32'(eb));
        chk($sformatf("%s frame%0d", name, c), 32'({fr[FRAME-1], fr[0]}), 32'h2);
`ifdef UART_EVEN_PARITY_EN
        chk($sformatf("%s parity%0d", name, c), 32'(fr[9]), 32'(^eb));
`endif
      end
      tick();
    end
    chk($sformatf("%s in_ready low during line", name), 32'(rdy_bad), 32'h0);
    chk($sformatf("%s no early done", name), 32'(done_bad), 32'h0);
    chk($sformatf("%s done at end", name), 32'(done), 32'h1);
    chk($sformatf("%s in_ready at done", name), 32'(in_ready), 32'h1);
    chk($sformatf("%s tx idle at done", name), 32'(tx), 32'h1);
  endtask

  // Watches an idle line for n cycles and counts anything that is not idle
  task automatic check_idle(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    chk(name, 32'(bad), 32'h0);
  endtask

  initial begin
    // Reset, with a capture attempt colliding with it
    rst      = 1'b1;
    in_valid = 1'b1;
    result   = 32'hDEADBEEF;
    tick();
    chk("reset tx", 32'(tx), 32'h1);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset done", 32'(done), 32'h0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post-reset tx", 32'(tx), 32'h1);
    chk("post-reset in_ready", 32'(in_ready), 32'h1);
    chk("post-reset done", 32'(done), 32'h0);
    check_idle("idle without valid", 20);

    // Plain line, flags clear
    capture(32'h0000001E, 3'b000);
    check_line("L1E", L_1E, 1'b0);
    tick();
    chk("L1E done one cycle", 32'(done), 32'h0);

    // All-F line with N set
    capture(32'hFFFFFFFD, 3'b100);
    check_line("LFFFD", L_FFFD, 1'b0);
    tick();
    chk("LFFFD done one cycle", 32'(done), 32'h0);

    // A capture attempt mid-line is ignored and nothing is queued
    capture(32'h89ABCDEF, 3'b001);
    check_line("L89AB", L_89AB, 1'b1);
    tick();
    chk("L89AB done one cycle", 32'(done), 32'h0);
    check_idle("no queued line", 3 * CHAR_CYC);

    // Back-to-back: a new capture presented in the done cycle
    capture(32'h00C0FFEE, 3'b111);
    check_line("LC0FFEE", L_C0FFEE, 1'b0);
    capture(32'h0000001E, 3'b000);
    check_line("b2b L1E", L_1E, 1'b0);
    tick();
    chk("b2b done one cycle", 32'(done), 32'h0);

    // Reset during the start bit of byte 3 abandons the line
    capture(32'hFFFFFFFD, 3'b100);
    repeat (3 * CHAR_CYC + 1) tick();
    chk("pre-abort tx start bit", 32'(tx), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort tx", 32'(tx), 32'h1);
    chk("abort in_ready", 32'(in_ready), 32'h1);
    chk("abort done", 32'(done), 32'h0);
    check_idle("abort stays idle", LINE_CYC);

    // Fresh line after the abort
    capture(32'h0000000A, 3'b010);
    check_line("L0A", L_0A, 1'b0);
    tick();
    chk("L0A done one cycle", 32'(done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
